// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer
// ------------------
// Parallel-to-serial stage feeding the serial sequence detector. Words are
// accepted over a valid/ready handshake and shifted out one bit per clock on
// data_out, qualified by bit_valid. Back-to-back words form a contiguous
// bitstream (GAP=0), so patterns spanning word boundaries remain visible to
// the detector. GAP idle cycles can optionally be inserted after each word.
//
// Handshake: a word transfers on a rising clk edge where
// load_valid && load_ready. load_data is sampled only at that edge; load_valid
// while load_ready=0 is ignored and nothing is latched.
//
// Parameters:
//   WIDTH      word width in bits (>=2)
//   GAP        idle cycles after each word (0 = contiguous stream)
//   MSB_FIRST  1: bit WIDTH-1 sent first, 0: bit 0 sent first
//
// Ports:
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   load_data   word to serialize
//   load_valid  upstream has a word
//   load_ready  block can accept a word this cycle
//   data_out    serial bit (0 whenever bit_valid=0)
//   bit_valid   data_out carries a valid bit
//   busy        FSM is not IDLE
//   word_done   one-cycle pulse on the last bit of a word
//
// Build option: define SER_PARITY_EN to append one even-parity bit (XOR of
// the latched word) after the data bits; the word then takes WIDTH+1 cycles
// and word_done / early ready move to the parity cycle.

module seq_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             data_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             word_done
);

`ifdef SER_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif
    localparam int CW = $clog2(NB);
    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             hs;
    logic             bit_d;
    logic             bit_valid_d;
    logic             data_out_d;
    logic             word_done_d;
    logic             load_ready_d;
    logic             busy_d;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    assign hs = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        shreg_d = shreg_q;
`ifdef SER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    shreg_d = load_data;
`ifdef SER_PARITY_EN
                    par_d   = ^load_data;
`endif
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    // hs can only be true here when GAP=0 (early ready).
                    if (hs) begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                        shreg_d = load_data;
`ifdef SER_PARITY_EN
                        par_d   = ^load_data;
`endif
                    end else if (GAP > 0) begin
                        state_d = ST_GAP;
                        gcnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (MSB_FIRST != 0) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    else                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                end
            end
            ST_GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    if (hs) begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                        shreg_d = load_data;
`ifdef SER_PARITY_EN
                        par_d   = ^load_data;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered: compute them from the next-state values so
        // they line up with the state the FSM enters at this edge.
        bit_d = (MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0];
`ifdef SER_PARITY_EN
        if (cnt_d == CW'(WIDTH)) bit_d = par_d;
`endif
        bit_valid_d  = (state_d == ST_SHIFT);
        data_out_d   = bit_valid_d & bit_d;
        word_done_d  = bit_valid_d && (cnt_d == CNT_LAST);
        busy_d       = (state_d != ST_IDLE);
        load_ready_d = (state_d == ST_IDLE)
                     || ((GAP == 0) && word_done_d)
                     || ((GAP > 0) && (state_d == ST_GAP) && (gcnt_d == GAP_LAST));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            gcnt_q     <= '0;
            shreg_q    <= '0;
`ifdef SER_PARITY_EN
            par_q      <= 1'b0;
`endif
            data_out   <= 1'b0;
            bit_valid  <= 1'b0;
            busy       <= 1'b0;
            word_done  <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gcnt_q     <= gcnt_d;
            shreg_q    <= shreg_d;
`ifdef SER_PARITY_EN
            par_q      <= par_d;
`endif
            data_out   <= data_out_d;
            bit_valid  <= bit_valid_d;
            busy       <= busy_d;
            word_done  <= word_done_d;
            load_ready <= load_ready_d;
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Testbench for seq_bit_serializer. Three instances cover the configurations:
//   u0: WIDTH=8 GAP=0 MSB_FIRST=1
//   u1: WIDTH=8 GAP=2 MSB_FIRST=1
//   u2: WIDTH=8 GAP=0 MSB_FIRST=0
// Inputs change and outputs are sampled on the falling clock edge.

module tb_seq_bit_serializer;

`ifdef SER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [7:0] ld [3];
    logic       lv [3];
    logic       lr [3];
    logic       dout [3];
    logic       bv [3];
    logic       bsy [3];
    logic       wd [3];

    seq_bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1)) u0 (
        .clk(clk), .rstn(rstn), .load_data(ld[0]), .load_valid(lv[0]),
        .load_ready(lr[0]), .data_out(dout[0]), .bit_valid(bv[0]),
        .busy(bsy[0]), .word_done(wd[0]));

    seq_bit_serializer #(.WIDTH(8), .GAP(2), .MSB_FIRST(1)) u1 (
        .clk(clk), .rstn(rstn), .load_data(ld[1]), .load_valid(lv[1]),
        .load_ready(lr[1]), .data_out(dout[1]), .bit_valid(bv[1]),
        .busy(bsy[1]), .word_done(wd[1]));

    seq_bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(0)) u2 (
        .clk(clk), .rstn(rstn), .load_data(ld[2]), .load_valid(lv[2]),
        .load_ready(lr[2]), .data_out(dout[2]), .bit_valid(bv[2]),
        .busy(bsy[2]), .word_done(wd[2]));

    // ---------------- scoring ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // stream holds bits in send order, stream[7] first; k==8 is the parity bit.
    function automatic logic exp_bit(input logic [7:0] stream, input logic par, input int k);
        logic b;
        if (k < 8) b = stream[7-k];
        else       b = par;
        return b;
    endfunction

    task automatic chk_bit(input int d, input int k, input logic e_dout,
                           input logic e_wd, input logic e_lr, input string tag);
        chk($sformatf("%s bit_valid k%0d", tag, k), {31'd0, bv[d]}, 32'd1);
        chk($sformatf("%s data_out k%0d", tag, k), {31'd0, dout[d]}, {31'd0, e_dout});
        chk($sformatf("%s word_done k%0d", tag, k), {31'd0, wd[d]}, {31'd0, e_wd});
        chk($sformatf("%s load_ready k%0d", tag, k), {31'd0, lr[d]}, {31'd0, e_lr});
        chk($sformatf("%s busy k%0d", tag, k), {31'd0, bsy[d]}, 32'd1);
    endtask

    task automatic chk_idle(input int d, input string tag);
        chk($sformatf("%s idle bit_valid", tag), {31'd0, bv[d]}, 32'd0);
        chk($sformatf("%s idle data_out", tag), {31'd0, dout[d]}, 32'd0);
        chk($sformatf("%s idle busy", tag), {31'd0, bsy[d]}, 32'd0);
        chk($sformatf("%s idle word_done", tag), {31'd0, wd[d]}, 32'd0);
        chk($sformatf("%s idle load_ready", tag), {31'd0, lr[d]}, 32'd1);
    endtask

    task automatic chk_gapcyc(input int d, input int g, input logic e_lr, input string tag);
        chk($sformatf("%s gap%0d bit_valid", tag, g), {31'd0, bv[d]}, 32'd0);
        chk($sformatf("%s gap%0d data_out", tag, g), {31'd0, dout[d]}, 32'd0);
        chk($sformatf("%s gap%0d busy", tag, g), {31'd0, bsy[d]}, 32'd1);
        chk($sformatf("%s gap%0d load_ready", tag, g), {31'd0, lr[d]}, {31'd0, e_lr});
    endtask

    // ---------------- driver ----------------
    // Send one word on instance d with a single-cycle valid. If pulse_k>=0,
    // load_valid is pulsed (with 8'hFF) during bit pulse_k, while the block is
    // busy and not ready; that pulse must be ignored.
    task automatic send_one(input int d, input int gap, input logic [7:0] word,
                            input logic [7:0] stream, input logic par,
                            input int pulse_k, input string tag);
        @(negedge clk);
        chk($sformatf("%s ready before load", tag), {31'd0, lr[d]}, 32'd1);
        ld[d] = word;
        lv[d] = 1'b1;
        @(negedge clk);
        lv[d] = 1'b0;
        ld[d] = ~word;
        for (int k = 0; k < NB; k++) begin
            if (k > 0) @(negedge clk);
            chk_bit(d, k, exp_bit(stream, par, k), k == NB-1,
                    (gap == 0) && (k == NB-1), tag);
            if (k == pulse_k) begin
                lv[d] = 1'b1;
                ld[d] = 8'hFF;
            end else if (k == pulse_k + 1) begin
                lv[d] = 1'b0;
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk_gapcyc(d, g, g == gap-1, tag);
        end
        @(negedge clk);
        chk_idle(d, tag);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0] word;
        logic [7:0] stream;   // MSB-first send order
        logic       par;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{word: 8'hA5, stream: 8'b1010_0101, par: 1'b0};
        tbl[1] = '{word: 8'h5A, stream: 8'b0101_1010, par: 1'b0};
        tbl[2] = '{word: 8'hFF, stream: 8'b1111_1111, par: 1'b0};
        tbl[3] = '{word: 8'h07, stream: 8'b0000_0111, par: 1'b1};
        tbl[4] = '{word: 8'h03, stream: 8'b0000_0011, par: 1'b0};
        tbl[5] = '{word: 8'h80, stream: 8'b1000_0000, par: 1'b1};
        tbl[6] = '{word: 8'h3C, stream: 8'b0011_1100, par: 1'b0};
        tbl[7] = '{word: 8'h01, stream: 8'b0000_0001, par: 1'b1};

        for (int d = 0; d < 3; d++) begin
            ld[d] = 8'h00;
            lv[d] = 1'b0;
        end
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk_idle(d, $sformatf("reset u%0d", d));
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Single words, MSB first, GAP=0.
        for (int i = 0; i < 8; i++)
            send_one(0, 0, tbl[i].word, tbl[i].stream, tbl[i].par, -1,
                     $sformatf("tbl%0d", i));

        // Back-to-back A5 then 5A with load_valid held: no bubble.
        @(negedge clk);
        ld[0] = 8'hA5;
        lv[0] = 1'b1;
        @(negedge clk);
        ld[0] = 8'h5A;
        for (int k = 0; k < 2*NB; k++) begin
            if (k > 0) @(negedge clk);
            chk_bit(0, k % NB,
                    exp_bit((k < NB) ? 8'b1010_0101 : 8'b0101_1010, 1'b0, k % NB),
                    (k % NB) == NB-1, (k % NB) == NB-1, "b2b");
            if (k == 2*NB-1) lv[0] = 1'b0;
        end
        @(negedge clk);
        chk_idle(0, "b2b");

        // GAP=2: valid held early is only taken on the final gap cycle.
        @(negedge clk);
        ld[1] = 8'hA5;
        lv[1] = 1'b1;
        @(negedge clk);
        ld[1] = 8'h5A;
        for (int k = 0; k < NB; k++) begin
            if (k > 0) @(negedge clk);
            chk_bit(1, k, exp_bit(8'b1010_0101, 1'b0, k), k == NB-1, 1'b0, "gap w0");
        end
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            chk_gapcyc(1, g, g == 1, "gap w0");
        end
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            chk_bit(1, k, exp_bit(8'b0101_1010, 1'b0, k), k == NB-1, 1'b0, "gap w1");
            if (k == 0) lv[1] = 1'b0;
        end
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            chk_gapcyc(1, g, g == 1, "gap w1");
        end
        @(negedge clk);
        chk_idle(1, "gap end");

        // LSB first: 8'h01 -> 1 then seven 0s; a valid pulse while busy is ignored.
        send_one(2, 0, 8'h01, 8'b1000_0000, 1'b1, 2, "lsb01");
        send_one(2, 0, 8'hA5, 8'b1010_0101, 1'b0, -1, "lsbA5");

        // Asynchronous reset during the 4th bit of 8'hFF.
        @(negedge clk);
        ld[0] = 8'hFF;
        lv[0] = 1'b1;
        @(negedge clk);
        lv[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk_bit(0, k, 1'b1, 1'b0, 1'b0, "pre-rst");
        end
        #2 rstn = 1'b0;
        #1;
        chk_idle(0, "midrst");
        @(negedge clk);
        rstn = 1'b1;
        send_one(0, 0, 8'h80, 8'b1000_0000, 1'b1, -1, "postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
